// File: rtl/lap_recorder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lap_recorder_pkg
// Purpose  : Shared definitions for the lap recorder: display state encoding,
//            BCD time width and the default lap store depth.
// Revision : 1.0  initial release
// ============================================================================
package lap_recorder_pkg;

    // 16-bit packed BCD time: {minutes, dekaseconds, seconds, deciseconds}
    localparam int TIME_W        = 16;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [0:0] {
        ST_LIVE   = 1'b0,
        ST_RECALL = 1'b1
    } lap_state_t;

endpackage : lap_recorder_pkg
`default_nettype wire

// File: rtl/lap_recorder_if.sv
`default_nettype none
// ============================================================================
// Module   : lap_recorder_if
// Purpose  : Bundles the stopwatch-side and display-side signals of the lap
//            recorder.
//   master : drives live_time and the three request pulses, observes display
//   slave  : the recorder itself (consumes pulses, produces display/status)
// Revision : 1.0  initial release
// ============================================================================
interface lap_recorder_if
    import lap_recorder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PW    = $clog2(DEPTH)
);
    logic [TIME_W-1:0] live_time;
    logic              lap_pulse;
    logic              view_pulse;
    logic              clear_pulse;
    logic [TIME_W-1:0] disp_time;
    logic              disp_is_lap;
    logic [PW-1:0]     lap_idx;
    logic [PW:0]       lap_count;
    logic              full;

    modport master (
        output live_time, lap_pulse, view_pulse, clear_pulse,
        input  disp_time, disp_is_lap, lap_idx, lap_count, full
    );

    modport slave (
        input  live_time, lap_pulse, view_pulse, clear_pulse,
        output disp_time, disp_is_lap, lap_idx, lap_count, full
    );
endinterface : lap_recorder_if
`default_nettype wire

// File: rtl/lap_buffer.sv
`default_nettype none
// ============================================================================
// Module   : lap_buffer
// Purpose  : Ring store of DEPTH lap times. Writes append at wr_ptr; when the
//            store is full the append lands on the oldest entry, so the ring
//            always holds the most recent DEPTH laps. Reads are addressed by
//            logical offset from the oldest entry.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            clear         - empty the store (pointer and count to zero)
//            wr_en/wr_data - append one lap
//            rd_offset     - logical index, 0 = oldest; rd_data combinational
//            lap_count     - number of valid laps, 0..DEPTH (registered)
//            full          - lap_count == DEPTH (registered)
// Revision : 1.0  initial release
// ============================================================================
module lap_buffer
    import lap_recorder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              wr_en,
    input  wire logic [TIME_W-1:0] wr_data,
    input  wire logic [PW-1:0]     rd_offset,
    output logic      [TIME_W-1:0] rd_data,
    output logic      [PW:0]       lap_count,
    output logic                   full
);
    localparam logic [PW:0]   C_DEPTH_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   C_CNT_ONE   = (PW+1)'(1);
    localparam logic [PW-1:0] C_PTR_ONE   = PW'(1);

    logic [TIME_W-1:0] mem_q [DEPTH];
    logic [TIME_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              full_q, full_d;
    logic [PW-1:0]     w_oldest;
    logic [PW-1:0]     w_rd_idx;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
            // When full, wr_ptr already points at the oldest entry; the
            // count simply saturates.
            if (!full_q) begin
                count_d = count_q + C_CNT_ONE;
            end
        end
        full_d = (count_d == C_DEPTH_CNT);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Truncating the count to PW bits maps DEPTH to 0, which makes the
    // oldest entry equal wr_ptr exactly when the ring is full.
    assign w_oldest  = wr_ptr_q - count_q[PW-1:0];
    assign w_rd_idx  = w_oldest + rd_offset;
    assign rd_data   = mem_q[w_rd_idx];
    assign lap_count = count_q;
    assign full      = full_q;

endmodule : lap_buffer
`default_nettype wire

// File: rtl/lap_recorder.sv
`default_nettype none
// ============================================================================
// Module   : lap_recorder
// Purpose  : Stopwatch lap capture and recall. In LIVE the display follows
//            live_time; lap_pulse captures it into the lap store. view_pulse
//            steps through stored laps oldest-first and then returns to LIVE.
//            clear_pulse empties the store. Display outputs are registered
//            with one cycle of latency from the controlling state.
// Ports    : clk, rst - clock, synchronous active-high reset
//            bus      - lap_recorder_if slave (pulses in, display/status out)
// Revision : 1.0  initial release
// ============================================================================
module lap_recorder
    import lap_recorder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  wire logic     clk,
    input  wire logic     rst,
    lap_recorder_if.slave bus
);
    localparam logic [PW:0]   C_CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] C_IDX_ONE = PW'(1);

    lap_state_t        state_q, state_d;
    logic [PW-1:0]     idx_q, idx_d;
    logic [TIME_W-1:0] disp_time_q, disp_time_d;
    logic              disp_is_lap_q, disp_is_lap_d;
    logic [PW-1:0]     lap_idx_q, lap_idx_d;

    logic              w_clear;
    logic              w_wr_en;
    logic [TIME_W-1:0] w_rd_data;
    logic [PW:0]       w_lap_count;
    logic              w_full;

    lap_buffer #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_lap_buffer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .wr_en     (w_wr_en),
        .wr_data   (bus.live_time),
        .rd_offset (idx_q),
        .rd_data   (w_rd_data),
        .lap_count (w_lap_count),
        .full      (w_full)
    );

    // Pulse priority: clear > lap > view; a losing pulse is dropped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        w_clear = 1'b0;
        w_wr_en = 1'b0;
        if (bus.clear_pulse) begin
            w_clear = 1'b1;
            state_d = ST_LIVE;
            idx_d   = '0;
        end else if (bus.lap_pulse) begin
            // Captures are only taken while the live time is on display.
            w_wr_en = (state_q == ST_LIVE);
        end else if (bus.view_pulse) begin
            if (state_q == ST_LIVE) begin
                if (w_lap_count != '0) begin
                    state_d = ST_RECALL;
                    idx_d   = '0;
                end
            end else if ({1'b0, idx_q} < (w_lap_count - C_CNT_ONE)) begin
                idx_d = idx_q + C_IDX_ONE;
            end else begin
                state_d = ST_LIVE;
                idx_d   = '0;
            end
        end

        // Display registers sample the current state, so a state change
        // reaches the outputs one edge after it takes effect.
        disp_is_lap_d = (state_q == ST_RECALL);
        disp_time_d   = (state_q == ST_RECALL) ? w_rd_data : bus.live_time;
        lap_idx_d     = idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LIVE;
            idx_q         <= '0;
            disp_time_q   <= '0;
            disp_is_lap_q <= 1'b0;
            lap_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            disp_time_q   <= disp_time_d;
            disp_is_lap_q <= disp_is_lap_d;
            lap_idx_q     <= lap_idx_d;
        end
    end

    assign bus.disp_time   = disp_time_q;
    assign bus.disp_is_lap = disp_is_lap_q;
    assign bus.lap_idx     = lap_idx_q;
    assign bus.lap_count   = w_lap_count;
    assign bus.full        = w_full;

endmodule : lap_recorder
`default_nettype wire

// File: tb/tb_lap_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lap_recorder
// Purpose  : Directed self-checking bench for lap_recorder (DEPTH = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_lap_recorder;
    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    lap_recorder_if #(.DEPTH(DEPTH), .PW(PW)) bus ();

    lap_recorder #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_lap(input logic [15:0] t);
        bus.live_time = t;
        bus.lap_pulse = 1'b1;
        tick();
        bus.lap_pulse = 1'b0;
    endtask

    task automatic pulse_view();
        bus.view_pulse = 1'b1;
        tick();
        bus.view_pulse = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_pulse = 1'b1;
        tick();
        bus.clear_pulse = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_eq({tag, "_disp"},  32'(bus.disp_time),   32'h0000);
        chk_eq({tag, "_islap"}, 32'(bus.disp_is_lap), 32'd0);
        chk_eq({tag, "_idx"},   32'(bus.lap_idx),     32'd0);
        chk_eq({tag, "_cnt"},   32'(bus.lap_count),   32'd0);
        chk_eq({tag, "_full"},  32'(bus.full),        32'd0);
    endtask

    initial begin
        n_total          = 0;
        n_bad            = 0;
        rst              = 1'b1;
        bus.live_time    = 16'h0000;
        bus.lap_pulse    = 1'b0;
        bus.view_pulse   = 1'b0;
        bus.clear_pulse  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_vals("rst");

        // Live tracking
        bus.live_time = 16'h1234;
        tick();
        tick();
        chk_eq("live_disp",  32'(bus.disp_time),   32'h1234);
        chk_eq("live_islap", 32'(bus.disp_is_lap), 32'd0);
        chk_eq("live_cnt",   32'(bus.lap_count),   32'd0);
        chk_eq("live_full",  32'(bus.full),        32'd0);

        // View with empty store is ignored
        pulse_view();
        tick();
        chk_eq("empty_view_islap", 32'(bus.disp_is_lap), 32'd0);
        chk_eq("empty_view_disp",  32'(bus.disp_time),   32'h1234);

        // Three laps then step through them
        pulse_lap(16'h0015);
        pulse_lap(16'h0102);
        pulse_lap(16'h0250);
        chk_eq("three_cnt",  32'(bus.lap_count), 32'd3);
        chk_eq("three_full", 32'(bus.full),      32'd0);
        pulse_view();
        tick();
        chk_eq("v1_disp",  32'(bus.disp_time),   32'h0015);
        chk_eq("v1_idx",   32'(bus.lap_idx),     32'd0);
        chk_eq("v1_islap", 32'(bus.disp_is_lap), 32'd1);
        pulse_view();
        tick();
        chk_eq("v2_disp", 32'(bus.disp_time), 32'h0102);
        chk_eq("v2_idx",  32'(bus.lap_idx),   32'd1);
        pulse_view();
        tick();
        chk_eq("v3_disp", 32'(bus.disp_time), 32'h0250);
        chk_eq("v3_idx",  32'(bus.lap_idx),   32'd2);
        pulse_view();
        tick();
        chk_eq("v4_islap", 32'(bus.disp_is_lap), 32'd0);
        chk_eq("v4_disp",  32'(bus.disp_time),   32'h0250);
        chk_eq("v4_idx",   32'(bus.lap_idx),     32'd0);

        // Recall at idx 1, lap ignored, then clear
        pulse_view();
        pulse_view();
        tick();
        chk_eq("r1_idx",  32'(bus.lap_idx),   32'd1);
        chk_eq("r1_disp", 32'(bus.disp_time), 32'h0102);
        pulse_lap(16'h0999);
        chk_eq("recall_lap_cnt", 32'(bus.lap_count), 32'd3);
        pulse_clear();
        chk_eq("clr_cnt",  32'(bus.lap_count), 32'd0);
        chk_eq("clr_full", 32'(bus.full),      32'd0);
        tick();
        chk_eq("clr_islap", 32'(bus.disp_is_lap), 32'd0);
        chk_eq("clr_disp",  32'(bus.disp_time),   32'h0999);

        // Overflow: five laps into four slots
        for (int i = 1; i <= 4; i++) pulse_lap(16'(i));
        chk_eq("four_full", 32'(bus.full),      32'd1);
        chk_eq("four_cnt",  32'(bus.lap_count), 32'd4);
        pulse_lap(16'h0005);
        chk_eq("five_full", 32'(bus.full),      32'd1);
        chk_eq("five_cnt",  32'(bus.lap_count), 32'd4);
        pulse_view();
        tick();
        chk_eq("ovf_disp0", 32'(bus.disp_time), 32'h0002);
        chk_eq("ovf_idx0",  32'(bus.lap_idx),   32'd0);
        pulse_view();
        pulse_view();
        pulse_view();
        tick();
        chk_eq("ovf_disp3", 32'(bus.disp_time), 32'h0005);
        chk_eq("ovf_idx3",  32'(bus.lap_idx),   32'd3);

        // Clear has priority over a same-cycle lap pulse
        bus.lap_pulse = 1'b1;
        pulse_clear();
        bus.lap_pulse = 1'b0;
        chk_eq("clr_vs_lap_cnt", 32'(bus.lap_count), 32'd0);

        // Lap beats view in the same cycle
        bus.view_pulse = 1'b1;
        pulse_lap(16'h0300);
        bus.view_pulse = 1'b0;
        chk_eq("lapview_cnt", 32'(bus.lap_count), 32'd1);
        tick();
        chk_eq("lapview_islap", 32'(bus.disp_is_lap), 32'd0);
        chk_eq("lapview_disp",  32'(bus.disp_time),   32'h0300);

        // Reset mid-recall overrides a concurrent view pulse
        bus.live_time = 16'h0777;
        pulse_view();
        tick();
        chk_eq("pre_rst_islap", 32'(bus.disp_is_lap), 32'd1);
        chk_eq("pre_rst_disp",  32'(bus.disp_time),   32'h0300);
        rst            = 1'b1;
        bus.view_pulse = 1'b1;
        tick();
        rst            = 1'b0;
        bus.view_pulse = 1'b0;
        chk_reset_vals("midrst");
        tick();
        chk_eq("post_rst_disp", 32'(bus.disp_time), 32'h0777);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_lap_recorder
`default_nettype wire

// File: doc/lap_recorder.md
LAP_RECORDER -- requirements
Module: lap_recorder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of stored laps (power of two, 2..8).
REQ-002 The block SHALL have parameter PW, default log2(DEPTH), giving the pointer and index width.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 live_time  input  16  running stopwatch time, BCD {minutes, dekaseconds, seconds, deciseconds}, 4 bits each.
REQ-006 lap_pulse  input  1  one-clk-wide request to capture live_time.
REQ-007 view_pulse  input  1  one-clk-wide request to enter recall or step to the next lap.
REQ-008 clear_pulse  input  1  one-clk-wide request to empty the lap store.
REQ-009 disp_time  output  16  BCD time to display, same packing as live_time.
REQ-010 disp_is_lap  output  1  high when disp_time is a stored lap, not live time.
REQ-011 lap_idx  output  PW  logical index of the displayed lap; 0 = oldest.
REQ-012 lap_count  output  PW+1  number of valid stored laps, 0..DEPTH.
REQ-013 full  output  1  high when lap_count == DEPTH.

Function
REQ-014 The FSM SHALL have two states:
- LIVE: disp_time tracks live_time.
- RECALL: disp_time shows stored lap lap_idx.
REQ-015 Storage SHALL be a ring of DEPTH 16-bit entries, with a write pointer wr_ptr and lap_count; oldest entry = (wr_ptr - lap_count) mod DEPTH.
REQ-016 lap_pulse in LIVE, not full: write live_time at wr_ptr, wr_ptr+1 mod DEPTH, lap_count+1.
REQ-017 lap_pulse in LIVE, full: overwrite the oldest entry at wr_ptr, wr_ptr+1 mod DEPTH; lap_count stays DEPTH, full stays 1.
REQ-018 lap_pulse in RECALL SHALL be ignored.
REQ-019 view_pulse in LIVE:
- lap_count > 0: go to RECALL, lap_idx = 0.
- lap_count == 0: ignored, no state change.
REQ-020 view_pulse in RECALL:
- lap_idx < lap_count-1: lap_idx+1.
- otherwise: return to LIVE, lap_idx = 0.
REQ-021 clear_pulse in any state: lap_count = 0, wr_ptr = 0, lap_idx = 0, state LIVE; entry contents are don't-care.
REQ-022 Priority within one cycle SHALL be clear_pulse > lap_pulse > view_pulse; a lower-priority pulse in the same cycle is discarded.
REQ-023 disp_time, disp_is_lap and lap_idx SHALL be registered: the values from the state and live_time at edge N appear after edge N+1 (one-cycle latency).
REQ-024 In LIVE: disp_time = live_time delayed one cycle, disp_is_lap = 0.
REQ-025 In RECALL: disp_time = entry at (oldest + lap_idx) mod DEPTH, disp_is_lap = 1.
REQ-026 lap_count and full SHALL be registered and update on the edge that performs the write or clear.
REQ-027 All pointer arithmetic SHALL wrap modulo DEPTH; lap_count SHALL never exceed DEPTH or go below 0.
REQ-028 live_time SHALL be stored verbatim, with no BCD validation or arithmetic.

Reset
REQ-029 On rst high at posedge clk: state LIVE, wr_ptr 0, lap_count 0, lap_idx 0, full 0, disp_is_lap 0, disp_time 16'h0000.
REQ-030 rst SHALL override all pulses in the same cycle, including mid-recall; storage contents need not be reset.

Structure
REQ-031 A shared package SHALL hold:
- the LIVE/RECALL state encoding;
- the BCD time width constant (16);
- the default DEPTH.
REQ-032 Storage and pointer logic SHALL be a sub-module lap_buffer (write port, read-by-logical-offset port, lap_count, full); lap_recorder holds the FSM and display registers.

Verification
REQ-033 Reset, then live_time=16'h1234 held -> 2 cycles later disp_time=16'h1234, disp_is_lap=0, lap_count=0, full=0.
REQ-034 lap_pulse at live_time 16'h0015, 16'h0102, 16'h0250, then view_pulse x3 -> disp_time 0015, 0102, 0250 with lap_idx 0,1,2; 4th view_pulse -> LIVE, disp_is_lap=0.
REQ-035 DEPTH=4: five lap_pulses at 0001..0005 -> full=1, lap_count=4; view_pulse -> disp_time=0002 (oldest survivor), lap_idx=0.
REQ-036 view_pulse with lap_count=0 -> stays LIVE, disp_is_lap=0; lap_pulse+view_pulse same cycle at live 0300 -> lap_count=1, stays LIVE.
REQ-037 In RECALL at lap_idx=1: clear_pulse -> next cycle lap_count=0, full=0, state LIVE; rst asserted mid-RECALL -> all REQ-029 values.
